// File: rtl/snoop_receptor_pkg.sv
// Shared encodings for the snoop receptor: line coherence states, snooped bus
// message types and the controller FSM states.
package snoop_receptor_pkg;

  typedef enum logic [1:0] {
    LS_INVALID   = 2'b00,
    LS_SHARED    = 2'b01,
    LS_EXCLUSIVE = 2'b10
  } line_state_e;

  typedef enum logic [1:0] {
    MSG_NONE       = 2'b00,
    MSG_READ_MISS  = 2'b01,
    MSG_WRITE_MISS = 2'b10,
    MSG_INVALIDATE = 2'b11
  } bus_msg_e;

  typedef enum logic [1:0] {
    FSM_IDLE   = 2'b00,
    FSM_CHECK  = 2'b01,
    FSM_WB     = 2'b10,
    FSM_UPDATE = 2'b11
  } fsm_state_e;

endpackage

// File: rtl/snoop_receptor_transicao.sv
// Coherence transition table: next line state and writeback need for a snooped
// message hitting a line in a given state. Purely combinational.
module snoop_transicao
  import snoop_receptor_pkg::*;
(
  input  logic [1:0] i_state,
  input  logic [1:0] i_msg,
  output logic [1:0] o_next_state,
  output logic       o_needs_wb
);

  always_comb begin
    o_next_state = LS_INVALID;
    o_needs_wb   = 1'b0;
    case (i_state)
      LS_EXCLUSIVE: begin
        case (i_msg)
          MSG_READ_MISS: begin
            o_next_state = LS_SHARED;
            o_needs_wb   = 1'b1;
          end
          MSG_WRITE_MISS: begin
            o_next_state = LS_INVALID;
            o_needs_wb   = 1'b1;
          end
          // Invalidate of an exclusive copy cannot legally happen; drop the line quietly.
          MSG_INVALIDATE: o_next_state = LS_INVALID;
          default:        o_next_state = LS_EXCLUSIVE;
        endcase
      end
      LS_SHARED: begin
        if ((i_msg == MSG_READ_MISS) || (i_msg == MSG_NONE)) begin
          o_next_state = LS_SHARED;
        end else begin
          o_next_state = LS_INVALID;
        end
      end
      default: o_next_state = LS_INVALID;
    endcase
  end

endmodule

// File: rtl/snoop_receptor.sv
// Snoop receptor for a small direct-mapped line directory; all state changes on
// the falling edge of Clk. Defining SNOOP_STATS_EN adds inval_count/wb_count.
module snoop_receptor
  import snoop_receptor_pkg::*;
#(
  parameter  int NUM_LINES = 4,
  parameter  int TAG_W     = 4,
  parameter  int WB_BEATS  = 4,
  localparam int IDX_W     = $clog2(NUM_LINES)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             bus_valid,
  input  logic [1:0]       bus_msg,
  input  logic [IDX_W-1:0] bus_index,
  input  logic [TAG_W-1:0] bus_tag,
  output logic             bus_ready,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_index,
  input  logic [TAG_W-1:0] upd_tag,
  input  logic [1:0]       upd_estado,
  output logic             hit,
  output logic             abort_mem,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [2:0]       wb_beat,
  output logic             wb_last,
  output logic [1:0]       estado_saida
`ifdef SNOOP_STATS_EN
  ,
  output logic [15:0]      inval_count,
  output logic [15:0]      wb_count
`endif
);

  localparam logic [2:0] LAST_BEAT = 3'(WB_BEATS - 1);

  fsm_state_e       r_state;
  fsm_state_e       w_state_next;
  logic [1:0]       r_msg;
  logic [IDX_W-1:0] r_index;
  logic [TAG_W-1:0] r_tag;
  logic [2:0]       r_beat;
  logic [1:0]       r_estado;

  logic [1:0]       w_line_st  [NUM_LINES];
  logic [TAG_W-1:0] w_line_tag [NUM_LINES];
  logic [1:0]       w_rd_st;
  logic [TAG_W-1:0] w_rd_tag;
  logic             w_match;
  logic [1:0]       w_trans_next;
  logic             w_trans_wb;
  logic [1:0]       w_check_est;
  logic             w_beat_last;
  logic             w_snoop_wr;

  assign w_rd_st     = w_line_st[r_index];
  assign w_rd_tag    = w_line_tag[r_index];
  assign w_match     = ((w_rd_st == LS_SHARED) || (w_rd_st == LS_EXCLUSIVE)) && (w_rd_tag == r_tag);
  assign w_check_est = w_match ? w_trans_next : LS_INVALID;
  assign w_beat_last = (r_beat == LAST_BEAT);
  // A same-cycle local write to the snooped line takes precedence over the snoop result.
  assign w_snoop_wr  = (r_state == FSM_UPDATE) && !(upd_valid && (upd_index == r_index));

  snoop_transicao u_transicao (
    .i_state      (w_rd_st),
    .i_msg        (r_msg),
    .o_next_state (w_trans_next),
    .o_needs_wb   (w_trans_wb)
  );

  always_ff @(negedge Clk) begin
    if (Rst) begin
      r_state <= FSM_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FSM_IDLE: begin
        if (bus_valid && (bus_msg != MSG_NONE)) w_state_next = FSM_CHECK;
      end
      FSM_CHECK: begin
        if (!w_match)        w_state_next = FSM_IDLE;
        else if (w_trans_wb) w_state_next = FSM_WB;
        else                 w_state_next = FSM_UPDATE;
      end
      FSM_WB: begin
        if (wb_ready && w_beat_last) w_state_next = FSM_UPDATE;
      end
      FSM_UPDATE: w_state_next = FSM_IDLE;
      default:    w_state_next = FSM_IDLE;
    endcase
  end

  always_comb begin
    bus_ready    = (r_state == FSM_IDLE);
    hit          = (r_state == FSM_CHECK) && w_match;
    abort_mem    = ((r_state == FSM_CHECK) && w_match && w_trans_wb) || (r_state == FSM_WB);
    wb_valid     = (r_state == FSM_WB);
    wb_last      = (r_state == FSM_WB) && w_beat_last;
    wb_beat      = r_beat;
    estado_saida = (r_state == FSM_CHECK) ? w_check_est : r_estado;
  end

  always_ff @(negedge Clk) begin
    if (Rst) begin
      r_msg    <= '0;
      r_index  <= '0;
      r_tag    <= '0;
      r_beat   <= '0;
      r_estado <= '0;
    end else begin
      if (bus_valid && (r_state == FSM_IDLE)) begin
        r_msg   <= bus_msg;
        r_index <= bus_index;
        r_tag   <= bus_tag;
      end
      if (r_state == FSM_CHECK) begin
        r_estado <= w_check_est;
        r_beat   <= '0;
      end else if ((r_state == FSM_WB) && wb_ready) begin
        r_beat <= w_beat_last ? 3'd0 : r_beat + 3'd1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LINES; gi++) begin : gen_line
      logic [1:0]       r_st;
      logic [TAG_W-1:0] r_tg;

      always_ff @(negedge Clk) begin
        if (Rst) begin
          r_st <= LS_INVALID;
          r_tg <= '0;
        end else if (upd_valid && (upd_index == IDX_W'(gi))) begin
          r_st <= upd_estado;
          r_tg <= upd_tag;
        end else if (w_snoop_wr && (r_index == IDX_W'(gi))) begin
          r_st <= r_estado;
        end
      end

      assign w_line_st[gi]  = r_st;
      assign w_line_tag[gi] = r_tg;
    end
  endgenerate

`ifdef SNOOP_STATS_EN
  logic [15:0] r_inval_cnt;
  logic [15:0] r_wb_cnt;

  always_ff @(negedge Clk) begin
    if (Rst) begin
      r_inval_cnt <= '0;
      r_wb_cnt    <= '0;
    end else begin
      if (w_snoop_wr && (r_estado == LS_INVALID) && (r_inval_cnt != 16'hFFFF)) begin
        r_inval_cnt <= r_inval_cnt + 16'd1;
      end
      if ((r_state == FSM_WB) && wb_ready && w_beat_last && (r_wb_cnt != 16'hFFFF)) begin
        r_wb_cnt <= r_wb_cnt + 16'd1;
      end
    end
  end

  assign inval_count = r_inval_cnt;
  assign wb_count    = r_wb_cnt;
`endif

endmodule

// File: tb/tb_snoop_receptor.sv
// Scoreboard bench for snoop_receptor: driver pushes expected responses from a
// line-directory model, a posedge monitor pops and compares per transaction.
module tb_snoop_receptor;
  import snoop_receptor_pkg::*;

  localparam int NL = 4;
  localparam int TW = 4;
  localparam int WB = 4;
  localparam int IW = 2;

  logic          Clk = 1'b1;
  logic          Rst = 1'b1;
  logic          bus_valid = 1'b0;
  logic [1:0]    bus_msg = 2'b00;
  logic [IW-1:0] bus_index = '0;
  logic [TW-1:0] bus_tag = '0;
  logic          bus_ready;
  logic          upd_valid = 1'b0;
  logic [IW-1:0] upd_index = '0;
  logic [TW-1:0] upd_tag = '0;
  logic [1:0]    upd_estado = 2'b00;
  logic          hit;
  logic          abort_mem;
  logic          wb_valid;
  logic          wb_ready = 1'b1;
  logic [2:0]    wb_beat;
  logic          wb_last;
  logic [1:0]    estado_saida;
`ifdef SNOOP_STATS_EN
  logic [15:0]   inval_count;
  logic [15:0]   wb_count;
`endif

  snoop_receptor #(.NUM_LINES(NL), .TAG_W(TW), .WB_BEATS(WB)) dut (
    .Clk(Clk), .Rst(Rst),
    .bus_valid(bus_valid), .bus_msg(bus_msg), .bus_index(bus_index), .bus_tag(bus_tag),
    .bus_ready(bus_ready),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_tag(upd_tag), .upd_estado(upd_estado),
    .hit(hit), .abort_mem(abort_mem),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_beat(wb_beat), .wb_last(wb_last),
    .estado_saida(estado_saida)
`ifdef SNOOP_STATS_EN
    , .inval_count(inval_count), .wb_count(wb_count)
`endif
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       hit;
    logic [1:0] est;
    logic       ab;
    int         nbeats;
    int         busy;
    int         icnt;
    int         wcnt;
  } exp_t;

  exp_t          expq[$];
  int            errors = 0;
  int            checks = 0;
  logic [1:0]    m_st  [NL];
  logic [TW-1:0] m_tag [NL];
  int            m_icnt = 0;
  int            m_wcnt = 0;
  bit            wbr_force = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT event never arrived within cycle budget (t=%0t)", name, $time);
  endtask

  // All driver activity happens 1 time unit after a falling edge.
  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (bus_ready === 1'b1) return;
      @(negedge Clk); #1;
    end
    timeout_fail("wait_idle");
  endtask

  task automatic wait_beat(input int n);
    for (int i = 0; i < 100; i++) begin
      if (wb_valid === 1'b1 && wb_beat == 3'(n)) return;
      @(negedge Clk); #1;
    end
    timeout_fail("wait_beat");
  endtask

  task automatic local_upd(input int idx, input logic [TW-1:0] tag, input logic [1:0] st);
    wait_idle();
    upd_valid = 1'b1; upd_index = IW'(idx); upd_tag = tag; upd_estado = st;
    @(negedge Clk); #1;
    upd_valid = 1'b0;
    m_st[idx] = st;
    m_tag[idx] = tag;
  endtask

  // Expected response from coherence rules: a valid copy with matching tag is hit;
  // a read miss leaves it shared, anything else kills it; exclusive data is written back.
  task automatic send(input logic [1:0] msg, input int idx, input logic [TW-1:0] tag);
    exp_t e;
    bit   wbn;
    logic [1:0] nxt;
    wait_idle();
    if (msg != MSG_NONE) begin
      e.hit = (m_st[idx] == LS_SHARED || m_st[idx] == LS_EXCLUSIVE) && (m_tag[idx] == tag);
      wbn = e.hit && (m_st[idx] == LS_EXCLUSIVE) && (msg != MSG_INVALIDATE);
      nxt = (msg == MSG_READ_MISS) ? LS_SHARED : LS_INVALID;
      e.est = e.hit ? nxt : LS_INVALID;
      e.ab = wbn;
      e.nbeats = wbn ? WB : 0;
      e.busy = !e.hit ? 1 : (wbn ? WB + 2 : 2);
      if (e.hit) begin
        m_st[idx] = nxt;
        if (nxt == LS_INVALID) m_icnt++;
      end
      if (wbn) m_wcnt++;
      e.icnt = m_icnt;
      e.wcnt = m_wcnt;
      expq.push_back(e);
    end
    bus_valid = 1'b1; bus_msg = msg; bus_index = IW'(idx); bus_tag = tag;
    @(negedge Clk); #1;
    bus_valid = 1'b0; bus_msg = MSG_NONE;
  endtask

  initial begin
    forever begin
      @(negedge Clk); #1;
      if (!wbr_force) wb_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: samples on the rising edge, midway between DUT updates.
  bit         mon_prev_rst = 1'b1;
  bit         mon_busy = 1'b0;
  int         mon_cyc, mon_stalls, mon_nb, mon_beat;
  logic       mon_hit, mon_ab;
  logic [1:0] mon_est;
  exp_t       mon_e;

  initial begin
    forever begin
      @(posedge Clk);
      if (mon_prev_rst) begin
        chk("rst_bus_ready", bus_ready, 1);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_beat", wb_beat, 0);
        chk("rst_wb_last", wb_last, 0);
        chk("rst_hit", hit, 0);
        chk("rst_abort_mem", abort_mem, 0);
        chk("rst_estado_saida", estado_saida, 0);
`ifdef SNOOP_STATS_EN
        chk("rst_inval_count", inval_count, 0);
        chk("rst_wb_count", wb_count, 0);
`endif
        mon_busy = 1'b0;
      end else if (bus_ready !== 1'b1) begin
        if (!mon_busy) begin
          mon_busy = 1'b1;
          mon_cyc = 0; mon_stalls = 0; mon_nb = 0; mon_beat = 0;
          mon_hit = hit; mon_est = estado_saida; mon_ab = abort_mem;
        end else begin
          chk("hit_one_cycle", hit, 0);
        end
        mon_cyc++;
        if (wb_valid === 1'b1) begin
          chk("wb_beat", wb_beat, mon_beat);
          chk("wb_last", wb_last, (mon_beat == WB - 1));
          chk("abort_mem_wb", abort_mem, 1);
          if (wb_ready) begin
            mon_beat++;
            mon_nb++;
          end else begin
            mon_stalls++;
          end
        end
      end else begin
        chk("idle_wb_valid", wb_valid, 0);
        if (mon_busy) begin
          mon_busy = 1'b0;
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_txn: DUT busy %0d cycles, required none", mon_cyc);
          end else begin
            mon_e = expq.pop_front();
            chk("hit", mon_hit, mon_e.hit);
            chk("estado_saida", mon_est, mon_e.est);
            chk("abort_mem_check", mon_ab, mon_e.ab);
            chk("wb_beats", mon_nb, mon_e.nbeats);
            chk("busy_cycles", mon_cyc - mon_stalls, mon_e.busy);
`ifdef SNOOP_STATS_EN
            chk("inval_count", inval_count, mon_e.icnt);
            chk("wb_count", wb_count, mon_e.wcnt);
`endif
          end
        end
      end
      mon_prev_rst = Rst;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required finish before t=400000");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NL; i++) begin
      m_st[i] = LS_INVALID;
      m_tag[i] = '0;
    end
    repeat (3) @(negedge Clk);
    #1;
    Rst = 1'b0;

    // shared hit, no writeback
    local_upd(1, 4'd5, LS_SHARED);
    send(MSG_READ_MISS, 1, 4'd5);

    // exclusive write miss: full writeback, line ends invalid
    wb_ready = 1'b1;
    local_upd(2, 4'd3, LS_EXCLUSIVE);
    send(MSG_WRITE_MISS, 2, 4'd3);
    send(MSG_READ_MISS, 2, 4'd3);

    // exclusive read miss with a five-cycle stall on beat 1
    local_upd(2, 4'd3, LS_EXCLUSIVE);
    send(MSG_READ_MISS, 2, 4'd3);
    wait_beat(1);
    wb_ready = 1'b0;
    repeat (5) begin
      @(negedge Clk); #1;
    end
    wb_ready = 1'b1;
    send(MSG_READ_MISS, 2, 4'd3);

    // tag mismatch leaves the line untouched
    local_upd(0, 4'd6, LS_SHARED);
    send(MSG_READ_MISS, 0, 4'd7);
    send(MSG_READ_MISS, 0, 4'd6);

    // local write colliding with the snoop write-back of state wins
    send(MSG_READ_MISS, 1, 4'd5);
    @(negedge Clk); #1;
    upd_valid = 1'b1; upd_index = 2'd1; upd_tag = 4'd5; upd_estado = LS_EXCLUSIVE;
    @(negedge Clk); #1;
    upd_valid = 1'b0;
    m_st[1] = LS_EXCLUSIVE;
    send(MSG_READ_MISS, 1, 4'd5);

    // local write during writeback does not cancel the snoop state write
    local_upd(2, 4'd3, LS_EXCLUSIVE);
    send(MSG_READ_MISS, 2, 4'd3);
    wait_beat(1);
    upd_valid = 1'b1; upd_index = 2'd2; upd_tag = 4'd3; upd_estado = LS_EXCLUSIVE;
    @(negedge Clk); #1;
    upd_valid = 1'b0;
    send(MSG_READ_MISS, 2, 4'd3);

    // empty message ignored; invalidate of an exclusive line drops it without writeback
    send(MSG_NONE, 0, 4'd6);
    send(MSG_READ_MISS, 0, 4'd6);
    local_upd(3, 4'd2, LS_EXCLUSIVE);
    send(MSG_INVALIDATE, 3, 4'd2);
    send(MSG_READ_MISS, 3, 4'd2);

    // randomized traffic with random writeback back-pressure
    wbr_force = 1'b0;
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 9) < 3) begin
        local_upd($urandom_range(0, NL - 1), TW'($urandom_range(0, 3)), 2'($urandom_range(0, 2)));
      end else begin
        send(2'($urandom_range(0, 3)), $urandom_range(0, NL - 1), TW'($urandom_range(0, 3)));
      end
    end

    // reset in the middle of a writeback
    wait_idle();
    wbr_force = 1'b1;
    wb_ready = 1'b1;
    local_upd(2, 4'd3, LS_EXCLUSIVE);
    local_upd(1, 4'd0, LS_SHARED);
    send(MSG_WRITE_MISS, 2, 4'd3);
    wait_beat(2);
    Rst = 1'b1;
    expq.delete();
    for (int i = 0; i < NL; i++) begin
      m_st[i] = LS_INVALID;
      m_tag[i] = '0;
    end
    m_icnt = 0;
    m_wcnt = 0;
    @(negedge Clk); #1;
    Rst = 1'b0;
    for (int i = 0; i < NL; i++) send(MSG_READ_MISS, i, 4'd0);
    send(MSG_READ_MISS, 2, 4'd3);

    wait_idle();
    repeat (4) @(negedge Clk);
    chk("queue_drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
